// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter slice: default widths, source
// encoding on the bus, and the round-robin winner selection helper.
package cdb_arbiter_pkg;

    localparam int ROB_SIZE_WIDTH = 4;
    localparam int CDB_Q_DEPTH    = 4;

    // Encoding of cdb_src: which producer the broadcast came from.
    typedef enum logic {
        CDB_SRC_ALU = 1'b0,
        CDB_SRC_LSB = 1'b1
    } cdb_src_e;

    // Round-robin pick between two candidates: a lone candidate wins,
    // and when both compete the one not granted last time wins.
    function automatic cdb_src_e pick_winner(
        input logic     alu_cand,
        input logic     lsb_cand,
        input cdb_src_e last_grant
    );
        cdb_src_e w;
        if (alu_cand && lsb_cand) begin
            if (last_grant == CDB_SRC_ALU) begin
                w = CDB_SRC_LSB;
            end else begin
                w = CDB_SRC_ALU;
            end
        end else if (lsb_cand) begin
            w = CDB_SRC_LSB;
        end else begin
            w = CDB_SRC_ALU;
        end
        return w;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small tag+data FIFO used once per CDB result producer. A push to a full
// FIFO is dropped (the producer side is expected to honour the stall).
// clear empties the FIFO synchronously and overrides push/pop.
module cdb_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against the current occupancy.
    always_comb begin
        full_s    = (count_r == CNT_W'(DEPTH));
        do_push_s = push && !full_s;
        do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s && !clear) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign empty = (count_r == {CNT_W{1'b0}});
    assign count = count_r;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers ALU and LSB results in per-source FIFOs,
// grants one broadcast per cycle round-robin, and drives a registered bus.
// Optional feature macro: CDB_BYPASS_EN lets a result arriving at an empty
// FIFO compete for the bus at the same edge (one-cycle minimum latency).
import cdb_arbiter_pkg::*;

module cdb_arbiter #(
    parameter int ROB_W   = ROB_SIZE_WIDTH,
    parameter int DATA_W  = 32,
    parameter int Q_DEPTH = CDB_Q_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rob_clear,
    input  logic              alu_ready,
    input  logic [ROB_W-1:0]  alu_rob_id,
    input  logic [DATA_W-1:0] alu_value,
    input  logic              lsb_ready,
    input  logic [ROB_W-1:0]  lsb_rob_id,
    input  logic [DATA_W-1:0] lsb_value,
    output logic              alu_stall,
    output logic              lsb_stall,
    output logic              cdb_valid,
    output logic [ROB_W-1:0]  cdb_rob_id,
    output logic [DATA_W-1:0] cdb_value,
    output logic              cdb_src
);

    localparam int ENTRY_W = ROB_W + DATA_W;
    localparam int CNT_W   = $clog2(Q_DEPTH) + 1;

    logic [ENTRY_W-1:0] alu_entry_s;
    logic [ENTRY_W-1:0] lsb_entry_s;
    logic [ENTRY_W-1:0] alu_head_s;
    logic [ENTRY_W-1:0] lsb_head_s;
    logic               alu_empty_s;
    logic               lsb_empty_s;
    logic [CNT_W-1:0]   alu_count_s;
    logic [CNT_W-1:0]   lsb_count_s;

    logic               active_s;
    logic               alu_byp_s;
    logic               lsb_byp_s;
    logic               alu_cand_s;
    logic               lsb_cand_s;
    logic               grant_s;
    cdb_src_e           winner_s;
    logic [ENTRY_W-1:0] win_entry_s;
    logic               alu_push_s;
    logic               alu_pop_s;
    logic               lsb_push_s;
    logic               lsb_pop_s;

    cdb_src_e           last_grant_r;
    cdb_src_e           last_grant_next_s;

    logic               cdb_valid_r;
    logic [ROB_W-1:0]   cdb_rob_id_r;
    logic [DATA_W-1:0]  cdb_value_r;
    cdb_src_e           cdb_src_r;

    assign alu_entry_s = {alu_rob_id, alu_value};
    assign lsb_entry_s = {lsb_rob_id, lsb_value};

    cdb_fifo #(.W(ENTRY_W), .DEPTH(Q_DEPTH)) u_alu_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (rob_clear),
        .push      (alu_push_s),
        .push_data (alu_entry_s),
        .pop       (alu_pop_s),
        .head      (alu_head_s),
        .empty     (alu_empty_s),
        .count     (alu_count_s)
    );

    cdb_fifo #(.W(ENTRY_W), .DEPTH(Q_DEPTH)) u_lsb_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (rob_clear),
        .push      (lsb_push_s),
        .push_data (lsb_entry_s),
        .pop       (lsb_pop_s),
        .head      (lsb_head_s),
        .empty     (lsb_empty_s),
        .count     (lsb_count_s)
    );

    // Candidate selection, winner mux and FIFO push/pop control for this edge.
    always_comb begin
        active_s = rdy && !rob_clear;
`ifdef CDB_BYPASS_EN
        alu_byp_s = alu_empty_s && alu_ready;
        lsb_byp_s = lsb_empty_s && lsb_ready;
`else
        alu_byp_s = 1'b0;
        lsb_byp_s = 1'b0;
`endif
        alu_cand_s = !alu_empty_s || alu_byp_s;
        lsb_cand_s = !lsb_empty_s || lsb_byp_s;
        grant_s    = active_s && (alu_cand_s || lsb_cand_s);
        winner_s   = pick_winner(alu_cand_s, lsb_cand_s, last_grant_r);

        win_entry_s = alu_head_s;
        if (winner_s == CDB_SRC_LSB) begin
            if (lsb_byp_s) begin
                win_entry_s = lsb_entry_s;
            end else begin
                win_entry_s = lsb_head_s;
            end
        end else begin
            if (alu_byp_s) begin
                win_entry_s = alu_entry_s;
            end else begin
                win_entry_s = alu_head_s;
            end
        end

        // A bypassed winner goes straight to the bus and is never stored.
        alu_pop_s  = grant_s && (winner_s == CDB_SRC_ALU) && !alu_empty_s;
        lsb_pop_s  = grant_s && (winner_s == CDB_SRC_LSB) && !lsb_empty_s;
        alu_push_s = active_s && alu_ready
                     && !(grant_s && (winner_s == CDB_SRC_ALU) && alu_byp_s);
        lsb_push_s = active_s && lsb_ready
                     && !(grant_s && (winner_s == CDB_SRC_LSB) && lsb_byp_s);
    end

    // Round-robin state: remembers the last granted source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= CDB_SRC_LSB;
        end else begin
            last_grant_r <= last_grant_next_s;
        end
    end

    // last_grant advances only when a broadcast is actually granted.
    always_comb begin
        last_grant_next_s = last_grant_r;
        if (grant_s) begin
            last_grant_next_s = winner_s;
        end else begin
            last_grant_next_s = last_grant_r;
        end
    end

    // Registered broadcast bus; payload holds when no winner, valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid_r  <= 1'b0;
            cdb_rob_id_r <= {ROB_W{1'b0}};
            cdb_value_r  <= {DATA_W{1'b0}};
            cdb_src_r    <= CDB_SRC_ALU;
        end else if (rob_clear) begin
            cdb_valid_r <= 1'b0;
        end else if (rdy) begin
            if (grant_s) begin
                cdb_valid_r  <= 1'b1;
                cdb_src_r    <= winner_s;
                cdb_rob_id_r <= win_entry_s[ENTRY_W-1:DATA_W];
                cdb_value_r  <= win_entry_s[DATA_W-1:0];
            end else begin
                cdb_valid_r <= 1'b0;
            end
        end
    end

    // Stalls look at occupancy only so one in-flight result always has room.
    assign alu_stall  = (alu_count_s >= CNT_W'(Q_DEPTH - 1));
    assign lsb_stall  = (lsb_count_s >= CNT_W'(Q_DEPTH - 1));

    assign cdb_valid  = cdb_valid_r;
    assign cdb_rob_id = cdb_rob_id_r;
    assign cdb_value  = cdb_value_r;
    assign cdb_src    = cdb_src_r;

endmodule
